// File: rtl/la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// la_capture_ctrl
//
// Capture sequencer for the tiny logic analyzer. Registers the 8-bit probe bus,
// evaluates a masked level/edge trigger, writes a DEPTH-sample window into an
// external single-port sample buffer, then streams that window back out over a
// valid/ready port.
//
// Optional feature macro: LA_PRETRIGGER_EN
//   defined   : the buffer is filled continuously while armed; the window holds
//               PRE samples before the trigger and the trigger is beat PRE.
//   undefined : nothing is written until the trigger; the trigger is beat 0.
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int PRE   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    probe,
  input  logic          arm,
  input  logic          abort,
  input  logic [7:0]    trig_mask,
  input  logic [7:0]    trig_value,
  input  logic          trig_edge,
  input  logic          rd_start,
  input  logic          rd_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          rd_valid,
  output logic [7:0]    rd_data,
  output logic          armed,
  output logic          done,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_t;

`ifdef LA_PRETRIGGER_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  // Samples written from the trigger onward (trigger sample included).
  localparam int              CAP_N     = PRE_EN ? (DEPTH - PRE) : DEPTH;
  localparam logic [AW:0]     CAP_N_C   = (AW+1)'(CAP_N);
  localparam logic [AW-1:0]   PRE_A     = AW'(PRE);
  localparam logic [AW-1:0]   LAST_BEAT = AW'(DEPTH - 1);
  localparam logic [AW-1:0]   A_ONE     = 1;
  localparam logic [AW:0]     C_ONE     = 1;

  // State and control registers
  state_t        r_state;
  state_t        w_next_state;
  logic          r_armed;
  logic          r_done;

  // Probe pipeline and trigger history
  logic [7:0]    r_s_q;
  logic          r_match_prev;

  // Capture bookkeeping
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_start_addr;
`ifdef LA_PRETRIGGER_EN
  logic [AW-1:0] r_fill;
`endif

  // Readout bookkeeping
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_beat;
  logic          r_rd_wait;

  // Registered outputs
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_wdata;
  logic          r_rd_valid;
  logic [7:0]    r_rd_data;

  // Trigger evaluation
  logic          w_match;
  logic          w_hit;
  logic          w_trig;
  logic          w_accept;
  logic [AW-1:0] w_trig_start;

  assign w_match  = ((r_s_q ^ trig_value) & trig_mask) == 8'h00;
  assign w_hit    = trig_edge ? (w_match & ~r_match_prev) : w_match;
  assign w_accept = r_rd_valid & rd_ready;

`ifdef LA_PRETRIGGER_EN
  // A trigger only counts once PRE history samples sit in the buffer.
  assign w_trig = w_hit & (r_fill == PRE_A);
`else
  assign w_trig = w_hit;
`endif

  // Window start: PRE samples before the trigger address, or address 0.
  assign w_trig_start = PRE_EN ? (r_wr_ptr - PRE_A) : '0;

  // State register plus registered armed/done flags decoded from next state.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_armed <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_armed <= (w_next_state == S_ARMED);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Next-state decode; abort overrides every other request.
  // NOTE: the default assignment first guarantees w_next_state is driven on
  // every path, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm) w_next_state = S_ARMED;
        end
        S_ARMED: begin
          if (w_trig) w_next_state = S_CAPTURE;
        end
        S_CAPTURE: begin
          // Stay one cycle past the last write so done follows it.
          if (r_count == CAP_N_C) w_next_state = S_DONE;
        end
        S_DONE: begin
          if (arm)           w_next_state = S_ARMED;
          else if (rd_start) w_next_state = S_READ;
        end
        S_READ: begin
          if (w_accept && (r_beat == LAST_BEAT)) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Probe register and edge-detect history (cleared whenever not staying armed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q        <= 8'h00;
      r_match_prev <= 1'b0;
    end else begin
      r_s_q        <= probe;
      r_match_prev <= ((r_state == S_ARMED) && (w_next_state == S_ARMED)) ? w_match : 1'b0;
    end
  end

  // Buffer write/read sequencing and readout handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_start_addr <= '0;
`ifdef LA_PRETRIGGER_EN
      r_fill       <= '0;
`endif
      r_rd_ptr     <= '0;
      r_beat       <= '0;
      r_rd_wait    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 8'h00;
    end else begin
      r_mem_we <= 1'b0;
      if (abort) begin
        // Drop any pending write and readout beat; restart bookkeeping.
        r_rd_valid <= 1'b0;
        r_rd_wait  <= 1'b0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
`ifdef LA_PRETRIGGER_EN
        r_fill     <= '0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_wr_ptr <= '0;
            r_count  <= '0;
`ifdef LA_PRETRIGGER_EN
            r_fill   <= '0;
`endif
          end

          S_ARMED: begin
            if (w_trig) begin
              r_mem_we     <= 1'b1;
              r_mem_addr   <= r_wr_ptr;
              r_mem_wdata  <= r_s_q;
              r_wr_ptr     <= r_wr_ptr + A_ONE;
              r_count      <= C_ONE;
              r_start_addr <= w_trig_start;
            end
`ifdef LA_PRETRIGGER_EN
            else begin
              // Rolling pre-trigger history; fill saturates at PRE.
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_wr_ptr;
              r_mem_wdata <= r_s_q;
              r_wr_ptr    <= r_wr_ptr + A_ONE;
              if (r_fill != PRE_A) r_fill <= r_fill + A_ONE;
            end
`endif
          end

          S_CAPTURE: begin
            if (r_count != CAP_N_C) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_wr_ptr;
              r_mem_wdata <= r_s_q;
              r_wr_ptr    <= r_wr_ptr + A_ONE;
              r_count     <= r_count + C_ONE;
            end
          end

          S_DONE: begin
            if (arm) begin
              r_wr_ptr <= '0;
              r_count  <= '0;
`ifdef LA_PRETRIGGER_EN
              r_fill   <= '0;
`endif
            end else if (rd_start) begin
              // Present the first address now; data is captured two edges on.
              r_mem_addr <= r_start_addr;
              r_rd_ptr   <= r_start_addr;
              r_beat     <= '0;
              r_rd_wait  <= 1'b1;
            end
          end

          S_READ: begin
            if (r_rd_valid) begin
              if (rd_ready) begin
                r_rd_valid <= 1'b0;
                r_rd_ptr   <= r_rd_ptr + A_ONE;
                r_beat     <= r_beat + A_ONE;
              end
            end else if (r_rd_wait) begin
              r_rd_wait <= 1'b0;
            end else begin
              // Capture the beat and prefetch the next address so the bubble
              // after each acceptance is a single cycle.
              r_rd_valid <= 1'b1;
              r_rd_data  <= mem_rdata;
              r_mem_addr <= r_rd_ptr + A_ONE;
            end
          end

          default: begin
            r_rd_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign armed     = r_armed;
  assign done      = r_done;
  assign state     = r_state;

endmodule
